// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit data memory on the responder side of
// the CPU load/store request/ack interface (four-phase handshake).
//
// Each accepted request performs exactly one access. The access completes
// WAIT_CYCLES+1 cycles after req is first sampled, with a one-cycle ack pulse.
// The initiator must then drop req for at least one edge before it issues
// another request.
//
// Parameters:
//   ADDR_W       word-address bits; depth = 2**ADDR_W words
//   WAIT_CYCLES  extra cycles between acceptance and ack (0..15)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   req    in   access request, held by the initiator until ack is seen
//   we     in   1 = write, 0 = read; sampled with req
//   addr   in   byte address; word index = addr[ADDR_W+1:2]
//   wdata  in   write data; sampled with req
//   ack    out  one-cycle completion pulse
//   rdata  out  read data; valid with ack and held until the next read completes
//   err    out  access error flag, valid with ack
//
// Build option: define MEM_RESP_ERR_EN to flag misaligned or out-of-range
// accesses. With the flag, err=1 on such accesses, the RAM is not written and
// rdata is unchanged. Without it, err is tied to 0 and addresses wrap modulo
// the depth.

module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_cfg_check
    $error("mem_responder: WAIT_CYCLES=%0d is outside 0..15", WAIT_CYCLES);
  end

  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];
  localparam int         DEPTH     = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t              state, next_state;
  logic [3:0]          cnt, cnt_next;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         mem [0:DEPTH-1];

  // Access attributes for the transaction in flight. A zero-wait access enters
  // RESP straight from IDLE, so its read must use the live inputs. Every other
  // access uses the copies latched at acceptance.
  logic                in_err;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_err;

`ifdef MEM_RESP_ERR_EN
  assign in_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
`else
  // Byte-offset and upper address bits are intentionally ignored (wrapping).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};
  assign in_err = 1'b0;
`endif

  assign acc_we  = (state == S_IDLE) ? we                : we_q;
  assign acc_idx = (state == S_IDLE) ? addr[ADDR_W+1:2]  : idx_q;
  assign acc_err = (state == S_IDLE) ? in_err            : err_q;

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned; this is what keeps always_comb free of latches.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_next   = WAIT_LOAD;
          next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          next_state = S_RESP;
        end
      end
      S_RESP: next_state = S_HOLD;
      S_HOLD: begin
        if (!req) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (state == S_IDLE && req) begin
        we_q    <= we;
        idx_q   <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
        err_q   <= in_err;
      end
      // The read is registered on entry to RESP, so rdata is valid with ack.
      if (next_state == S_RESP && state != S_RESP && !acc_we && !acc_err) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  // NOTE: the RAM array is deliberately left out of reset. Its contents
  // persist across reset, and an unreset array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ack = (state == S_RESP);

`ifdef MEM_RESP_ERR_EN
  assign err = ack & err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Three instances cover WAIT_CYCLES of
// 1, 0 and 3. Each has its own req line and shares the other inputs. A table of
// accesses runs through a scoreboard queue, and hand-written sequences cover
// held req, early req drop, input changes after acceptance, address wrap or
// error flagging, and reset during a wait.

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_v;
  logic        we_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [31:0] rdata_v [3];

  always #5 clk = ~clk;

  // sel 0: WAIT_CYCLES=1, sel 1: WAIT_CYCLES=0, sel 2: WAIT_CYCLES=3
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  int lat_of [3] = '{2, 1, 4};

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
  } exp_t;
  exp_t sb_q [$];

  typedef struct {
    int          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [13];

  logic [31:0] last_rd [3];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Waits for ack on one instance; lat counts posedges since acceptance began.
  task automatic wait_ack(input int sel, inout int lat, output bit got);
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack_v[sel]) got = 1;
    end
  endtask

  task automatic run_access(input string name, input int sel, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_er);
    exp_t e;
    int   lat;
    bit   got;
    sb_q.push_back('{rd: exp_rd, er: exp_er, lat: lat_of[sel]});
    @(negedge clk);
    we_s = w; addr_s = a; wdata_s = d; req_v[sel] = 1'b1;
    lat = 0;
    wait_ack(sel, lat, got);
    e = sb_q.pop_front();
    check({name, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, lat, e.lat);
      check({name, "_rdata"}, rdata_v[sel], e.rd);
      check({name, "_err"}, 32'(err_v[sel]), 32'(e.er));
      @(posedge clk);
      #1;
      check({name, "_ack_pulse"}, 32'(ack_v[sel]), 32'd0);
    end
    @(negedge clk);
    req_v[sel] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int  n;
    int  lat;
    bit  got;

    vecs[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 1'b1, 32'h14,  32'h12345678, 32'h0};
    vecs[3]  = '{0, 1'b0, 32'h14,  32'h0,        32'h12345678};
    vecs[4]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
    vecs[5]  = '{0, 1'b1, 32'hFFC, 32'h0F0F0F0F, 32'h0};
    vecs[6]  = '{0, 1'b0, 32'hFFC, 32'h0,        32'h0F0F0F0F};
    vecs[7]  = '{1, 1'b1, 32'h8,   32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1, 1'b0, 32'h8,   32'h0,        32'hCAFEF00D};
    vecs[9]  = '{2, 1'b1, 32'h40,  32'hA5A5A5A5, 32'h0};
    vecs[10] = '{2, 1'b0, 32'h40,  32'h0,        32'hA5A5A5A5};
    vecs[11] = '{2, 1'b1, 32'h40,  32'h5A5A5A5A, 32'h0};
    vecs[12] = '{2, 1'b0, 32'h40,  32'h0,        32'h5A5A5A5A};

    // Reset: held for 3 cycles, then 10 idle cycles with no ack.
    reset = 1'b1; req_v = 3'b000; we_s = 1'b0; addr_s = 32'h0; wdata_s = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ack%0d", i), 32'(ack_v[i]), 32'd0);
      check($sformatf("reset_err%0d", i), 32'(err_v[i]), 32'd0);
      check($sformatf("reset_rdata%0d", i), rdata_v[i], 32'd0);
      last_rd[i] = 32'd0;
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ack_v != 3'b000) n++;
    end
    check("idle_no_ack", n, 0);

    // Table-driven accesses.
    for (int i = 0; i < 13; i++) begin
      int s;
      s = vecs[i].sel;
      if (vecs[i].we) begin
        run_access($sformatf("vec%0d", i), s, 1'b1, vecs[i].addr, vecs[i].wdata,
                   last_rd[s], 1'b0);
      end else begin
        run_access($sformatf("vec%0d", i), s, 1'b0, vecs[i].addr, 32'h0,
                   vecs[i].exp_rd, 1'b0);
        last_rd[s] = vecs[i].exp_rd;
      end
    end

    // WAIT_CYCLES=0: req held high for 3 cycles after ack gives exactly one ack.
    @(negedge clk);
    we_s = 1'b0; addr_s = 32'h8; req_v[1] = 1'b1;
    @(posedge clk);
    #1;
    check("w0_first_ack", 32'(ack_v[1]), 32'd1);
    check("w0_first_rdata", rdata_v[1], 32'hCAFEF00D);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack_v[1]) n++;
    end
    check("w0_held_no_reack", n, 0);
    @(negedge clk);
    req_v[1] = 1'b0;
    @(posedge clk);
    run_access("w0_second", 1, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);

    // Early req drop: the write still completes with normal latency.
    @(negedge clk);
    we_s = 1'b1; addr_s = 32'h44; wdata_s = 32'h13579BDF; req_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[2] = 1'b0;
    lat = 1;
    wait_ack(2, lat, got);
    check("viol_ack_seen", 32'(got), 32'd1);
    check("viol_latency", lat, 4);
    @(posedge clk);
    #1;
    check("viol_ack_pulse", 32'(ack_v[2]), 32'd0);
    @(posedge clk);
    run_access("viol_readback", 2, 1'b0, 32'h44, 32'h0, 32'h13579BDF, 1'b0);
    last_rd[2] = 32'h13579BDF;

    // Inputs changed after acceptance are ignored.
    run_access("latch_pre", 2, 1'b1, 32'h54, 32'h22, last_rd[2], 1'b0);
    @(negedge clk);
    we_s = 1'b1; addr_s = 32'h50; wdata_s = 32'h11; req_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we_s = 1'b0; addr_s = 32'h54; wdata_s = 32'h99;
    lat = 1;
    wait_ack(2, lat, got);
    check("latch_ack_seen", 32'(got), 32'd1);
    check("latch_rdata_kept", rdata_v[2], last_rd[2]);
    @(posedge clk);
    @(negedge clk);
    req_v[2] = 1'b0;
    @(posedge clk);
    run_access("latch_rd50", 2, 1'b0, 32'h50, 32'h0, 32'h11, 1'b0);
    run_access("latch_rd54", 2, 1'b0, 32'h54, 32'h0, 32'h22, 1'b0);
    last_rd[2] = 32'h22;

`ifdef MEM_RESP_ERR_EN
    // Misaligned write and out-of-range read are flagged and have no effect.
    run_access("err_pre", 0, 1'b1, 32'h10, 32'h77, last_rd[0], 1'b0);
    run_access("err_misalign_wr", 0, 1'b1, 32'h13, 32'hBAD0BAD0, last_rd[0], 1'b1);
    run_access("err_ram4_kept", 0, 1'b0, 32'h10, 32'h0, 32'h77, 1'b0);
    last_rd[0] = 32'h77;
    run_access("err_range_rd", 0, 1'b0, 32'h1000, 32'h0, 32'h77, 1'b1);
`else
    // Addresses wrap modulo the depth; the byte offset is ignored.
    run_access("wrap_wr0", 0, 1'b1, 32'h0, 32'h1, last_rd[0], 1'b0);
    run_access("wrap_wr1000", 0, 1'b1, 32'h1000, 32'h2, last_rd[0], 1'b0);
    run_access("wrap_rd0", 0, 1'b0, 32'h0, 32'h0, 32'h2, 1'b0);
    run_access("wrap_rd_offset", 0, 1'b0, 32'h3, 32'h0, 32'h2, 1'b0);
    last_rd[0] = 32'h2;
`endif

    // Reset during WAIT drops the pending write.
    run_access("rst_pre", 0, 1'b1, 32'h20, 32'hAA, last_rd[0], 1'b0);
    @(negedge clk);
    we_s = 1'b1; addr_s = 32'h20; wdata_s = 32'h55; req_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_wait_no_ack", 32'(ack_v[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1; req_v[0] = 1'b0;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack_v[0]) n++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack_v[0]) n++;
    end
    check("rst_mid_no_ack", n, 0);
    check("rst_mid_rdata", rdata_v[0], 32'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
    run_access("rst_old_value", 0, 1'b0, 32'h20, 32'h0, 32'hAA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
